// File: rtl/segment_capture_sequencer_pkg.sv
// Shared capture package: FSM state encoding, segment-mode constants and
// a small state-decode helper used by the sequencer.
package segment_capture_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_GAP     = 3'd3,
      ST_FINISH  = 3'd4,
      ST_ERROR   = 3'd5
   } state_t;

   // seg_mode values
   localparam logic MODE_GO    = 1'b0;  // each segment waits for capture_go
   localparam logic MODE_TIMED = 1'b1;  // segments start every seg_cycles clocks

   // States in which the trigger unit is kept armed.
   function automatic logic is_armed(input state_t s);
      return (s == ST_ARMED) || (s == ST_CAPTURE) || (s == ST_GAP);
   endfunction

endpackage

// File: rtl/segment_capture_sequencer_if.sv
// Trigger-unit / sample-FIFO handshake bundle.
//   capture_go  : one-cycle start pulse from the trigger unit
//   fifo_full   : sample FIFO cannot accept a write this cycle
//   trig_arm_o  : arm input of the trigger unit
//   trig_done_o : capture-done input of the trigger unit
//   sample_wr_o : FIFO write enable, one sample per cycle
// master = sequencer side, slave = trigger/FIFO side.
interface segment_capture_sequencer_if;
   logic capture_go;
   logic fifo_full;
   logic trig_arm_o;
   logic trig_done_o;
   logic sample_wr_o;

   modport master (
      input  capture_go,
      input  fifo_full,
      output trig_arm_o,
      output trig_done_o,
      output sample_wr_o
   );

   modport slave (
      output capture_go,
      output fifo_full,
      input  trig_arm_o,
      input  trig_done_o,
      input  sample_wr_o
   );
endinterface

// File: rtl/segment_capture_sequencer_seg_period_counter.sv
// Saturating segment-period counter.
//   clk, reset_n : clock and synchronous active-low reset
//   clear        : restart at 0 (asserted on the cycle before a segment's first sample)
//   period       : segment period in clocks
//   reach        : counter has reached (or passed) period-1
module seg_period_counter #(
   parameter int CYC_W = 20
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic [CYC_W-1:0] period,
   output logic             reach
);

   logic [CYC_W-1:0] cnt_r;

   // Free-running count that sticks at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_r <= '0;
      end else if (clear) begin
         cnt_r <= '0;
      end else if (cnt_r != {CYC_W{1'b1}}) begin
         cnt_r <= cnt_r + {{(CYC_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // cnt+1 >= period, evaluated one bit wider so period=0 cannot underflow.
   assign reach = ({1'b0, cnt_r} + {{CYC_W{1'b0}}, 1'b1}) >= {1'b0, period};

endmodule

// File: rtl/segment_capture_sequencer.sv
// Segmented capture sequencer: arms the trigger unit, emits bursts of
// FIFO writes per segment (started by capture_go or by a fixed period),
// and reports completion or FIFO overrun. All outputs are registered.
//   adc_clk, reset_n : clock, synchronous active-low reset
//   arm_req          : level; rising edge starts a capture, low aborts
//   seg_mode         : 0 = capture_go per segment, 1 = timed segments
//   num_segments/num_samples/seg_cycles : capture configuration (0 -> 1 for counts)
//   bus              : trigger/FIFO handshake (master side)
//   seg_count_o      : completed segments
//   busy_o, done_o, overflow_o : status
module segment_capture_sequencer
   import segment_capture_sequencer_pkg::*;
#(
   parameter int NSEG_W  = 16,
   parameter int NSAMP_W = 17,
   parameter int CYC_W   = 20
) (
   input  logic                        adc_clk,
   input  logic                        reset_n,
   input  logic                        arm_req,
   input  logic                        seg_mode,
   input  logic [NSEG_W-1:0]           num_segments,
   input  logic [NSAMP_W-1:0]          num_samples,
   input  logic [CYC_W-1:0]            seg_cycles,
   segment_capture_sequencer_if.master bus,
   output logic [NSEG_W-1:0]           seg_count_o,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        overflow_o
);

   state_t             state_r, state_s;
   logic               arm_prev_r;
   logic               mode_r;
   logic [NSEG_W-1:0]  nseg_r;
   logic [NSAMP_W-1:0] nsamp_r;
   logic [CYC_W-1:0]   cyc_r;
   logic [NSAMP_W-1:0] samp_cnt_r;
   logic [NSEG_W-1:0]  seg_count_r;
   logic               trig_arm_r, trig_done_r, sample_wr_r, busy_r, done_r, overflow_r;

   logic               arm_rise_s, seg_done_s, seg_start_s, samp_last_s, cyc_reach_s;
   logic [NSEG_W-1:0]  seg_next_s;

   assign samp_last_s = (samp_cnt_r + {{(NSAMP_W-1){1'b0}}, 1'b1}) == nsamp_r;
   assign seg_next_s  = seg_count_r + {{(NSEG_W-1){1'b0}}, 1'b1};
   // Counter restarts so that it reads 0 on the first CAPTURE cycle.
   assign seg_start_s = (state_s == ST_CAPTURE) && (state_r != ST_CAPTURE);

   seg_period_counter #(.CYC_W(CYC_W)) u_period (
      .clk     (adc_clk),
      .reset_n (reset_n),
      .clear   (seg_start_s),
      .period  (cyc_r),
      .reach   (cyc_reach_s)
   );

   // Next-state decode; arm_req low is checked first so abort wins over everything.
   always_comb begin
      state_s    = state_r;
      arm_rise_s = 1'b0;
      seg_done_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (arm_req && !arm_prev_r) begin
               state_s    = ST_ARMED;
               arm_rise_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ARMED: begin
            if (!arm_req) begin
               state_s = ST_IDLE;
            end else if (bus.capture_go) begin
               state_s = ST_CAPTURE;
            end else begin
               state_s = ST_ARMED;
            end
         end
         ST_CAPTURE: begin
            if (!arm_req) begin
               state_s = ST_IDLE;
            end else if (bus.fifo_full) begin
               state_s = ST_ERROR;
            end else if (samp_last_s) begin
               seg_done_s = 1'b1;
               state_s    = (seg_next_s == nseg_r) ? ST_FINISH : ST_GAP;
            end else begin
               state_s = ST_CAPTURE;
            end
         end
         ST_GAP: begin
            if (!arm_req) begin
               state_s = ST_IDLE;
            end else if (mode_r == MODE_GO) begin
               state_s = bus.capture_go ? ST_CAPTURE : ST_GAP;
            end else begin
               state_s = cyc_reach_s ? ST_CAPTURE : ST_GAP;
            end
         end
         ST_FINISH, ST_ERROR: begin
            if (!arm_req) begin
               state_s = ST_IDLE;
            end else begin
               state_s = state_r;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State register, arm edge history, configuration shadows and sample counter.
   always_ff @(posedge adc_clk) begin
      if (!reset_n) begin
         state_r    <= ST_IDLE;
         arm_prev_r <= 1'b0;
         mode_r     <= 1'b0;
         nseg_r     <= '0;
         nsamp_r    <= '0;
         cyc_r      <= '0;
         samp_cnt_r <= '0;
      end else begin
         state_r    <= state_s;
         arm_prev_r <= arm_req;
         if (arm_rise_s) begin
            mode_r  <= seg_mode;
            nseg_r  <= (num_segments == '0) ? {{(NSEG_W-1){1'b0}}, 1'b1} : num_segments;
            nsamp_r <= (num_samples == '0) ? {{(NSAMP_W-1){1'b0}}, 1'b1} : num_samples;
            cyc_r   <= seg_cycles;
         end
         if (seg_start_s) begin
            samp_cnt_r <= '0;
         end else if (state_r == ST_CAPTURE) begin
            samp_cnt_r <= samp_cnt_r + {{(NSAMP_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // Registered outputs derived from the upcoming state.
   always_ff @(posedge adc_clk) begin
      if (!reset_n) begin
         seg_count_r <= '0;
         overflow_r  <= 1'b0;
         trig_arm_r  <= 1'b0;
         trig_done_r <= 1'b0;
         sample_wr_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         if (arm_rise_s) begin
            seg_count_r <= '0;
         end else if (seg_done_s) begin
            seg_count_r <= seg_next_s;
         end
         if (arm_rise_s) begin
            overflow_r <= 1'b0;
         end else if (state_s == ST_ERROR) begin
            overflow_r <= 1'b1;
         end
         trig_arm_r  <= is_armed(state_s);
         trig_done_r <= (state_s == ST_FINISH) || (state_s == ST_ERROR);
         sample_wr_r <= (state_s == ST_CAPTURE);
         busy_r      <= (state_s != ST_IDLE);
         done_r      <= (state_s == ST_FINISH) && (state_r != ST_FINISH);
      end
   end

   assign bus.trig_arm_o  = trig_arm_r;
   assign bus.trig_done_o = trig_done_r;
   assign bus.sample_wr_o = sample_wr_r;
   assign seg_count_o     = seg_count_r;
   assign busy_o          = busy_r;
   assign done_o          = done_r;
   assign overflow_o      = overflow_r;

endmodule

// File: tb/tb_segment_capture_sequencer.sv
module tb_segment_capture_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        arm_req;
   logic        seg_mode;
   logic [15:0] num_segments;
   logic [16:0] num_samples;
   logic [19:0] seg_cycles;
   logic [15:0] seg_count_o;
   logic        busy_o, done_o, overflow_o;

   segment_capture_sequencer_if bus();

   segment_capture_sequencer #(.NSEG_W(16), .NSAMP_W(17), .CYC_W(20)) dut (
      .adc_clk      (clk),
      .reset_n      (reset_n),
      .arm_req      (arm_req),
      .seg_mode     (seg_mode),
      .num_segments (num_segments),
      .num_samples  (num_samples),
      .seg_cycles   (seg_cycles),
      .bus          (bus),
      .seg_count_o  (seg_count_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .overflow_o   (overflow_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc_n = 0;
   int done_cnt = 0;
   int wr_q[$];
   int go_q[$];
   int exp_q[$];

   // Observer: timestamps accepted writes, capture_go pulses and done pulses.
   always @(negedge clk) begin
      cyc_n = cyc_n + 1;
      if (bus.sample_wr_o === 1'b1 && bus.fifo_full === 1'b0) wr_q.push_back(cyc_n);
      if (bus.capture_go === 1'b1) go_q.push_back(cyc_n);
      if (done_o === 1'b1) done_cnt = done_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_obs();
      wr_q.delete();
      go_q.delete();
      done_cnt = 0;
   endtask

   // Reference schedule: list of cycles on which writes must occur.
   task automatic build_expected(input logic mode, input int nseg_e, input int ns_e, input int sc);
      int segs;
      int cur_end;
      int p;
      exp_q.delete();
      if (go_q.size() == 0) return;
      if (mode == 1'b0) begin
         // every capture_go that arrives after the previous burst starts the next one
         segs = 0;
         cur_end = -1;
         foreach (go_q[i]) begin
            if (segs < nseg_e && go_q[i] > cur_end) begin
               for (int j = 0; j < ns_e; j++) exp_q.push_back(go_q[i] + 1 + j);
               cur_end = go_q[i] + ns_e;
               segs++;
            end
         end
      end else begin
         // bursts spaced by the period, but never closer than one idle cycle
         p = (sc > ns_e + 1) ? sc : ns_e + 1;
         for (int k = 0; k < nseg_e; k++)
            for (int j = 0; j < ns_e; j++) exp_q.push_back(go_q[0] + 1 + k * p + j);
      end
   endtask

   task automatic run_capture(input string tag, input logic mode, input int nseg, input int nsamp,
                              input int sc, input int gmin, input int gmax);
      int n;
      int k;
      int nseg_e;
      int ns_e;
      nseg_e = (nseg == 0) ? 1 : nseg;
      ns_e   = (nsamp == 0) ? 1 : nsamp;
      arm_req = 1'b0;
      tick();
      tick();
      seg_mode     = mode;
      num_segments = 16'(nseg);
      num_samples  = 17'(nsamp);
      seg_cycles   = 20'(sc);
      clear_obs();
      arm_req = 1'b1;
      tick();
      // configuration changes after arming must have no effect
      num_segments = 16'd9;
      num_samples  = 17'd9;
      seg_cycles   = 20'd3;
      seg_mode     = ~mode;
      chk($sformatf("%s arm", tag), 32'(bus.trig_arm_o), 32'd1);
      chk($sformatf("%s ovf_clr", tag), 32'(overflow_o), 32'd0);
      chk($sformatf("%s cnt_clr", tag), 32'(seg_count_o), 32'd0);
      bus.capture_go = 1'b1;
      tick();
      bus.capture_go = 1'b0;
      n = 0;
      while (done_cnt == 0 && n < 3000) begin
         k = $urandom_range(gmax, gmin);
         repeat (k) tick();
         n = n + k + 1;
         if (mode == 1'b0) begin
            bus.capture_go = 1'b1;
            tick();
            bus.capture_go = 1'b0;
         end else begin
            bus.capture_go = ($urandom_range(1, 0) == 1) ? 1'b1 : 1'b0;
            tick();
            bus.capture_go = 1'b0;
         end
      end
      tick();
      tick();
      build_expected(mode, nseg_e, ns_e, sc);
      chk($sformatf("%s done_cnt", tag), 32'(done_cnt), 32'd1);
      chk($sformatf("%s nwr", tag), 32'(wr_q.size()), 32'(exp_q.size()));
      if (wr_q.size() == exp_q.size())
         foreach (exp_q[i]) chk($sformatf("%s wr%0d", tag, i), 32'(wr_q[i]), 32'(exp_q[i]));
      chk($sformatf("%s segcnt", tag), 32'(seg_count_o), 32'(nseg_e));
      chk($sformatf("%s tdone", tag), 32'(bus.trig_done_o), 32'd1);
      chk($sformatf("%s tarm_off", tag), 32'(bus.trig_arm_o), 32'd0);
      chk($sformatf("%s ovf", tag), 32'(overflow_o), 32'd0);
      arm_req = 1'b0;
      tick();
      chk($sformatf("%s idle", tag), 32'(busy_o), 32'd0);
      chk($sformatf("%s tdone_off", tag), 32'(bus.trig_done_o), 32'd0);
   endtask

   initial begin
      reset_n        = 1'b0;
      arm_req        = 1'b0;
      seg_mode       = 1'b0;
      num_segments   = 16'd0;
      num_samples    = 17'd0;
      seg_cycles     = 20'd0;
      bus.capture_go = 1'b0;
      bus.fifo_full  = 1'b0;
      repeat (3) tick();
      chk("rst busy", 32'(busy_o), 32'd0);
      chk("rst done", 32'(done_o), 32'd0);
      chk("rst ovf", 32'(overflow_o), 32'd0);
      chk("rst segcnt", 32'(seg_count_o), 32'd0);
      chk("rst tarm", 32'(bus.trig_arm_o), 32'd0);
      chk("rst tdone", 32'(bus.trig_done_o), 32'd0);
      chk("rst wr", 32'(bus.sample_wr_o), 32'd0);
      reset_n = 1'b1;
      tick();

      // go-driven segments, timed segments, back-to-back timed, zero counts
      run_capture("go3x4", 1'b0, 3, 4, 0, 0, 7);
      run_capture("timed10", 1'b1, 2, 4, 10, 0, 3);
      run_capture("timed2", 1'b1, 3, 5, 2, 0, 3);
      run_capture("zero", 1'b0, 0, 0, 0, 1, 3);

      // FIFO full on the 3rd write
      seg_mode = 1'b0; num_segments = 16'd1; num_samples = 17'd8; seg_cycles = 20'd0;
      clear_obs();
      arm_req = 1'b1;
      tick();
      bus.capture_go = 1'b1;
      tick();
      bus.capture_go = 1'b0;
      tick();
      tick();
      bus.fifo_full = 1'b1;
      tick();
      bus.fifo_full = 1'b0;
      chk("ovf wr_off", 32'(bus.sample_wr_o), 32'd0);
      chk("ovf flag", 32'(overflow_o), 32'd1);
      chk("ovf tdone", 32'(bus.trig_done_o), 32'd1);
      chk("ovf tarm", 32'(bus.trig_arm_o), 32'd0);
      repeat (3) tick();
      chk("ovf nwr", 32'(wr_q.size()), 32'd2);
      chk("ovf nodone", 32'(done_cnt), 32'd0);
      arm_req = 1'b0;
      tick();
      chk("ovf idle", 32'(busy_o), 32'd0);
      chk("ovf sticky", 32'(overflow_o), 32'd1);

      // abort coincident with capture_go in ARMED
      tick();
      clear_obs();
      arm_req = 1'b1;
      tick();
      arm_req = 1'b0;
      bus.capture_go = 1'b1;
      tick();
      bus.capture_go = 1'b0;
      chk("abort busy", 32'(busy_o), 32'd0);
      chk("abort tarm", 32'(bus.trig_arm_o), 32'd0);
      chk("abort wr", 32'(bus.sample_wr_o), 32'd0);
      repeat (2) tick();
      chk("abort nwr", 32'(wr_q.size()), 32'd0);
      chk("abort nodone", 32'(done_cnt), 32'd0);

      // abort mid-CAPTURE holds seg_count and emits no done
      num_segments = 16'd3; num_samples = 17'd3;
      clear_obs();
      arm_req = 1'b1;
      tick();
      bus.capture_go = 1'b1;
      tick();
      bus.capture_go = 1'b0;
      repeat (4) tick();
      bus.capture_go = 1'b1;
      tick();
      bus.capture_go = 1'b0;
      arm_req = 1'b0;
      tick();
      chk("abortcap segcnt", 32'(seg_count_o), 32'd1);
      chk("abortcap wr", 32'(bus.sample_wr_o), 32'd0);
      chk("abortcap tdone", 32'(bus.trig_done_o), 32'd0);
      tick();
      chk("abortcap nodone", 32'(done_cnt), 32'd0);

      // reset in the middle of a capture
      num_segments = 16'd2; num_samples = 17'd8;
      clear_obs();
      arm_req = 1'b1;
      tick();
      bus.capture_go = 1'b1;
      tick();
      bus.capture_go = 1'b0;
      tick();
      tick();
      reset_n = 1'b0;
      arm_req = 1'b0;
      tick();
      chk("mrst busy", 32'(busy_o), 32'd0);
      chk("mrst wr", 32'(bus.sample_wr_o), 32'd0);
      chk("mrst tarm", 32'(bus.trig_arm_o), 32'd0);
      chk("mrst tdone", 32'(bus.trig_done_o), 32'd0);
      chk("mrst segcnt", 32'(seg_count_o), 32'd0);
      reset_n = 1'b1;
      tick();
      chk("mrst nodone", 32'(done_cnt), 32'd0);
      run_capture("after_rst", 1'b0, 2, 3, 0, 0, 4);

      // randomized configurations
      for (int r = 0; r < 10; r++) begin
         run_capture($sformatf("rnd%0d", r), ($urandom_range(1, 0) == 1) ? 1'b1 : 1'b0,
                     $urandom_range(4, 0), $urandom_range(6, 0), $urandom_range(14, 0), 0, 6);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/segment_capture_sequencer.md
SEGMENT_CAPTURE_SEQUENCER -- requirements
Module: segment_capture_sequencer

Interface
REQ-001 SHALL have parameter NSEG_W, default 16, width of the segment count.
REQ-002 SHALL have parameter NSAMP_W, default 17, width of the per-segment sample count.
REQ-003 SHALL have parameter CYC_W, default 20, width of the segment-period count.
REQ-004 adc_clk  in  1  sole clock; reset_n  in  1  synchronous, active-low reset.
REQ-005 arm_req  in  1  level from the register block; rising edge starts a capture, low aborts it.
REQ-006 seg_mode  in  1  0 = each segment waits for capture_go; 1 = segments start every seg_cycles clocks.
REQ-007 num_segments  in  NSEG_W  segments per capture; 0 is treated as 1.
REQ-008 num_samples  in  NSAMP_W  samples per segment; 0 is treated as 1.
REQ-009 seg_cycles  in  CYC_W  segment period in clocks for seg_mode=1.
REQ-010 capture_go  in  1  one-cycle start pulse from the trigger unit.
REQ-011 fifo_full  in  1  sample FIFO cannot accept a write this cycle.
REQ-012 trig_arm_o  out  1  drives the trigger unit arm input.
REQ-013 trig_done_o  out  1  drives the trigger unit capture-done input.
REQ-014 sample_wr_o  out  1  FIFO write enable, one sample per cycle.
REQ-015 seg_count_o  out  NSEG_W  number of completed segments.
REQ-016 busy_o  out  1  high in any state except IDLE.
REQ-017 done_o  out  1  one-cycle pulse on normal completion.
REQ-018 overflow_o  out  1  sticky FIFO overrun flag.

Function
REQ-019 States: IDLE, ARMED, CAPTURE, GAP, FINISH, ERROR; all outputs registered.
REQ-020 IDLE: on arm_req=1 with the previous-cycle arm_req=0 -> ARMED; clear seg_count_o and overflow_o; set trig_arm_o=1 on the next cycle.
REQ-021 ARMED: capture_go=1 -> CAPTURE; sample_wr_o=1 on the next cycle; clear sample and cycle counters.
REQ-022 CAPTURE: sample_wr_o=1 every cycle; after the num_samples-th write, increment seg_count_o and go to FINISH if the new count equals num_segments, else to GAP.
REQ-023 CAPTURE: ignore capture_go.
REQ-024 GAP, seg_mode=0: capture_go -> CAPTURE.
REQ-025 GAP, seg_mode=1: ignore capture_go; -> CAPTURE when the cycle counter reaches seg_cycles-1.
REQ-026 Cycle counter starts at 0 on the first CAPTURE cycle of each segment and saturates at all-ones; if it is already >= seg_cycles-1 on GAP entry, leave GAP on the next cycle.
REQ-027 Cycle counter SHALL count in all segments, independent of seg_mode.
REQ-028 FINISH: trig_done_o=1 and trig_arm_o=0; pulse done_o for exactly one cycle on entry.
REQ-029 FINISH: hold until arm_req=0, then -> IDLE with trig_done_o=0.
REQ-030 fifo_full=1 in CAPTURE -> ERROR in the same evaluation; no write that cycle.
REQ-031 ERROR: overflow_o=1, trig_done_o=1, trig_arm_o=0, no done_o; exit to IDLE on arm_req=0.
REQ-032 arm_req=0 in ARMED, CAPTURE or GAP -> IDLE next cycle.
REQ-033 On that abort: trig_arm_o=0, sample_wr_o=0, seg_count_o held, no done_o.
REQ-034 Abort SHALL take priority over simultaneous capture_go, fifo_full or segment completion.
REQ-035 Configuration inputs are sampled once, on the IDLE->ARMED transition, and held in shadow registers for the whole capture.
REQ-036 seg_count_o wraps modulo 2^NSEG_W only if num_segments is all-ones; no other counter wraps.

Reset
REQ-037 reset_n=0 at a clock edge forces: state IDLE, all outputs 0, all counters and shadow registers 0, regardless of state.
REQ-038 Reset asserted mid-capture emits no done_o or trig_done_o pulse.

Structure
REQ-039 State encoding and the seg_mode constants SHALL live in the shared capture package.
REQ-040 A single sub-module, seg_period_counter, is natural: the saturating cycle counter with its compare output.
REQ-041 No other hierarchy; target size 150-300 lines.

Verification
REQ-042 seg_mode=0, num_segments=3, num_samples=4, three capture_go pulses -> 12 writes in three bursts of 4; seg_count_o ends at 3; exactly one done_o.
REQ-043 seg_mode=1, seg_cycles=10, num_samples=4, num_segments=2, one capture_go -> write bursts start 10 clocks apart.
REQ-044 seg_mode=1, seg_cycles=2, num_samples=5 -> second burst starts one cycle after the first ends; no write gaps elsewhere.
REQ-045 fifo_full raised on the 3rd write -> 2 writes total, overflow_o=1, trig_done_o=1, no done_o; arm_req=0 -> IDLE.
REQ-046 arm_req dropped in the same cycle as capture_go in ARMED -> no writes, IDLE next cycle.
REQ-047 reset_n=0 mid-CAPTURE -> all outputs 0 next cycle; a fresh arm_req edge restarts cleanly.
REQ-048 num_samples=0 and num_segments=0 -> one segment of one sample, then done_o.
